// File: rtl/err_sweep_ctrl_pkg.sv
// Shared types and constants for the approximate-adder error sweep controller.
package err_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Result widths: worst-case sweep error sum stays below 2^25,
  // mismatch count reaches 65536, a single error is at most 511.
  localparam int unsigned SUM_W     = 25;
  localparam int unsigned CNT_W     = 17;
  localparam int unsigned ERR_W     = 9;
  localparam int unsigned SWEEP_LEN = 65536;

  // Absolute difference of two 9-bit sums.
  function automatic logic [ERR_W-1:0] abs_diff9(input logic [8:0] x, input logic [8:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/err_sweep_ctrl_adder.sv
// 8-bit ripple-carry adder whose low APPROX_BITS cells are approximate:
// sum = a AND NOT cin, carry out forced to 1. Upper cells are exact.
module rc8_approx_adder #(
  parameter int unsigned APPROX_BITS = 7
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] sum
);

  logic [8:0] c;

  // Ripple through the eight cells; carry into cell 0 is zero.
  always_comb begin
    c   = '0;
    sum = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < APPROX_BITS) begin
        sum[i]   = a[i] & ~c[i];
        c[i+1]   = 1'b1;
      end else begin
        sum[i]   = a[i] ^ b[i] ^ c[i];
        c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
    end
    sum[8] = c[8];
  end

endmodule

// File: rtl/err_sweep_ctrl.sv
// Error-statistics controller: evaluates the approximate adder against the
// exact sum for one operand pair or all 65536 pairs and accumulates
// total error, mismatch count, maximum error and the last approximate sum.
module err_sweep_ctrl
  import err_sweep_ctrl_pkg::*;
#(
  parameter int unsigned APPROX_BITS = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             single,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] err_sum,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ERR_W-1:0] max_err,
  output logic [8:0]       last_sum
);

  localparam logic [15:0] LAST_K = 16'(SWEEP_LEN - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        mode_single;
  logic [7:0]  a_lat, b_lat;
  logic [7:0]  iss_a, iss_b;
  logic [8:0]  approx_w, exact_w;
  logic [8:0]  p_approx, p_exact;
  logic        p_vld;
  logic [ERR_W-1:0] abs_err;
  logic        last_issue;
  logic        accept;
  logic        do_abort;

  assign accept     = (state == ST_IDLE) && start;
  assign do_abort   = abort && ((state == ST_RUN) || (state == ST_DRAIN));
  assign last_issue = mode_single || (cnt == LAST_K);

  // Sweep order: low byte of the counter is a, high byte is b.
  assign iss_a   = mode_single ? a_lat : cnt[7:0];
  assign iss_b   = mode_single ? b_lat : cnt[15:8];
  assign exact_w = {1'b0, iss_a} + {1'b0, iss_b};
  assign abs_err = abs_diff9(p_approx, p_exact);

  rc8_approx_adder #(
    .APPROX_BITS(APPROX_BITS)
  ) u_adder (
    .a   (iss_a),
    .b   (iss_b),
    .sum (approx_w)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort)           state_nxt = ST_IDLE;
        else if (last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (abort) state_nxt = ST_IDLE;
        else       state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pair issue, one-stage sum pipeline and result accumulation.
  // Abort drops the in-flight pair so partial results stay as they were.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      mode_single <= 1'b0;
      a_lat       <= '0;
      b_lat       <= '0;
      p_approx    <= '0;
      p_exact     <= '0;
      p_vld       <= 1'b0;
      err_sum     <= '0;
      err_cnt     <= '0;
      max_err     <= '0;
      last_sum    <= '0;
    end else if (accept) begin
      cnt         <= '0;
      mode_single <= single;
      a_lat       <= op_a;
      b_lat       <= op_b;
      p_vld       <= 1'b0;
      err_sum     <= '0;
      err_cnt     <= '0;
      max_err     <= '0;
      last_sum    <= '0;
    end else if (do_abort) begin
      p_vld <= 1'b0;
    end else begin
      if (state == ST_RUN) begin
        p_approx <= approx_w;
        p_exact  <= exact_w;
        p_vld    <= 1'b1;
        if (!last_issue) cnt <= cnt + 16'd1;
      end else begin
        p_vld <= 1'b0;
      end
      if (p_vld) begin
        err_sum  <= err_sum + SUM_W'(abs_err);
        err_cnt  <= err_cnt + CNT_W'(abs_err != '0);
        if (abs_err > max_err) max_err <= abs_err;
        last_sum <= p_approx;
      end
    end
  end

endmodule

// File: doc/err_sweep_ctrl.md
ERR_SWEEP_CTRL -- requirements
Module: err_sweep_ctrl

Interface
REQ-001 Parameter: APPROX_BITS, default 7, number of low-order approximate cells (0..8) in the evaluated 8-bit ripple-carry adder.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request evaluation; accepted only in IDLE.
REQ-005 single  input  1  sampled with accepted start: 1 = evaluate op_a/op_b only, 0 = exhaustive sweep of all 65536 pairs.
REQ-006 op_a, op_b  input  8 each  operands for single mode; sampled with accepted start.
REQ-007 abort  input  1  cancel an evaluation in progress.
REQ-008 busy  output  1  high in RUN and DRAIN.
REQ-009 done  output  1  one-cycle pulse on completion.
REQ-010 err_sum  output  25  sum of |approx - exact| over evaluated pairs (MAE = err_sum/65536 for sweep).
REQ-011 err_cnt  output  17  number of pairs with approx != exact.
REQ-012 max_err  output  9  largest |approx - exact|.
REQ-013 last_sum  output  9  approximate sum of the last accumulated pair.

Function
REQ-014 States IDLE, RUN, DRAIN, DONE; DONE lasts one cycle then returns to IDLE.
REQ-015 IDLE + start: go RUN, clear pair counter (16 bit) and all result registers, latch single/op_a/op_b.
REQ-016 Sweep order: counter k from 0 to 65535, a = k[7:0], b = k[15:8]; single mode issues exactly one pair (op_a, op_b).
REQ-017 One pair issued per RUN cycle; RUN -> DRAIN after last pair issued; counter never wraps.
REQ-018 Pipeline: approx and exact 9-bit sums registered one stage, then absolute error accumulated in the following edge.
REQ-019 DRAIN lasts one cycle (accumulates last pair), then DONE with done = 1.
REQ-020 Latency from start-accepting edge to done high: 65537 cycles sweep, 2 cycles single.
REQ-021 Exact sum = a + b, 9 bit unsigned; absolute error 9 bit unsigned.
REQ-022 Approx cell i < APPROX_BITS: sum = a_i AND NOT cin_i, cout = 1; cells i >= APPROX_BITS: exact full adder; carry into cell 0 = 0; bit 8 = carry out of cell 7.
REQ-023 Accumulators sized so no overflow occurs (max sweep err_sum < 2^25).
REQ-024 Result outputs hold stable from DONE until next accepted start.
REQ-025 start while busy or in DONE ignored.
REQ-026 abort in RUN/DRAIN: next state IDLE, no done pulse, partial results held; abort in IDLE/DONE ignored; abort has priority over pipeline accumulation in the same cycle.
REQ-027 start and abort together in IDLE: start accepted.

Reset
REQ-028 rst_n low at a rising edge: state IDLE, counter 0, pipeline registers 0, busy 0, done 0, err_sum/err_cnt/max_err/last_sum 0.
REQ-029 Reset mid-RUN discards the evaluation with no done pulse.

Structure
REQ-030 Shared package holds state enum, result widths (25/17/9) and sweep length constant 65536.
REQ-031 One sub-module, rc8_approx_adder (combinational, parameter APPROX_BITS), implements REQ-022; controller instantiates it once.

Verification
REQ-032 APPROX_BITS=7, single, a=0x00 b=0x00 -> done at +2, last_sum=128, err_sum=128, err_cnt=1, max_err=128.
REQ-033 APPROX_BITS=7, single, a=0xFF b=0x00 -> last_sum=257, err_sum=2, max_err=2; a=0x01 b=0x01 -> last_sum=129, err_sum=127.
REQ-034 APPROX_BITS=0, sweep -> done exactly 65537 cycles after accept, err_sum=0, err_cnt=0, max_err=0, last_sum=0x1FE.
REQ-035 APPROX_BITS=7, sweep -> err_sum/err_cnt/max_err equal software model of REQ-022 over all 65536 pairs.
REQ-036 abort at cycle 100 of sweep -> IDLE next cycle, no done, busy 0; start pulse while busy ignored.
REQ-037 rst_n low mid-sweep -> all outputs 0 next cycle, subsequent start runs full sweep correctly.
